fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 clk  in  1  system clock; all state updates on the rising edge.
REQ-002 rst_n  in  1  reset, asynchronous and active-low.
REQ-003 br_valid  in  1  single-cycle branch/jump redirect pulse from decode.
REQ-004 br_target  in  32  branch redirect address.
REQ-005 ex_valid  in  1  single-cycle exception/ERET redirect pulse from writeback.
REQ-006 ex_target  in  32  exception/ERET redirect address.
REQ-007 inst_req  out  1  instruction memory request.
REQ-008 inst_addr  out  32  request address, always equal to the fetch PC register.
REQ-009 inst_addr_ok  in  1  memory accepts the request.
REQ-010 inst_data_ok  in  1  read data valid.
REQ-011 inst_rdata  in  32  read data.
REQ-012 fs_valid  out  1  fetched instruction valid toward decode.
REQ-013 fs_pc  out  32  PC of the fetched instruction.
REQ-014 fs_inst  out  32  fetched instruction word.
REQ-015 ds_allowin  in  1  decode accepts fs_* this cycle.
REQ-016 fs_adel  out  1  misaligned fetch flag; present only when FETCH_ALIGN_CHECK_EN is defined.

Function
REQ-017 The block SHALL hold one 32-bit fetch PC; sequential next PC = PC+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-018 The block SHALL implement the FSM states REQ, WAIT, HOLD and DROP, with at most one request outstanding.
REQ-019 REQ: inst_req=1; on inst_addr_ok -> WAIT.
REQ-020 WAIT: inst_req=0; on inst_data_ok, capture inst_rdata and PC into fs_inst/fs_pc -> HOLD.
REQ-021 HOLD: fs_valid=1, inst_req=0; on ds_allowin, PC <= PC+4 -> REQ.
REQ-022 DROP: inst_req=0, fs_valid=0; on inst_data_ok, discard the data -> REQ.
REQ-023 fs_valid SHALL be asserted only in HOLD; latency SHALL be one cycle from inst_data_ok to fs_valid.
REQ-024 Redirect SHALL be ex_valid, or br_valid when ex_valid is low; ex wins when both are high, and PC SHALL load the winning target in the redirect cycle.
REQ-025 Redirect in REQ without inst_addr_ok: load PC, stay in REQ; inst_addr changes to the new target next cycle.
REQ-026 Redirect in REQ with inst_addr_ok, or in WAIT without inst_data_ok: load PC -> DROP.
REQ-027 Redirect in WAIT with inst_data_ok: discard the data, load PC -> REQ.
REQ-028 Redirect in HOLD: drop fs_valid next cycle regardless of ds_allowin, load PC -> REQ.
REQ-029 Redirect in DROP: load PC, stay in DROP (the old response is still owed).
REQ-030 inst_addr_ok or inst_data_ok in a state not expecting it SHALL be ignored.

Reset
REQ-031 While rst_n=0 the block SHALL force: PC=0x0040_0000, state=REQ, fs_valid=0, fs_pc=0, fs_inst=0, fs_adel=0.
REQ-032 Reset asserted mid-transaction SHALL abandon any outstanding request; after release, the first inst_req SHALL carry 0x0040_0000 on the first clock edge.

Configuration
REQ-033 With FETCH_ALIGN_CHECK_EN defined and PC[1:0]!=0 in REQ: inst_req SHALL stay 0, and the block SHALL go to HOLD with fs_valid=1, fs_adel=1, fs_inst=0, fs_pc=PC; this HOLD exits only by redirect.
REQ-034 Without FETCH_ALIGN_CHECK_EN: the fs_adel port SHALL be absent, and misaligned PCs SHALL be fetched unchanged.

Verification
REQ-035 Reset release; addr_ok and data_ok each one cycle after request, ds_allowin=1 -> inst_addr 0x0040_0000, then 0x0040_0004; fs_valid with fs_inst=rdata one cycle after each data_ok.
REQ-036 HOLD with ds_allowin=0 for 3 cycles -> fs_valid, fs_pc and fs_inst stable; no new inst_req until the cycle after ds_allowin=1.
REQ-037 br_valid (target 0x0040_0100) in WAIT -> DROP; first data_ok is discarded with no fs_valid; next inst_addr=0x0040_0100.
REQ-038 ex_valid (0xBFC0_0380) and br_valid (0x0040_0100) in the same cycle in HOLD -> fs_valid falls; next inst_addr=0xBFC0_0380.
REQ-039 PC=0xFFFF_FFFC consumed -> next inst_addr=0x0000_0000; rst_n pulsed low during WAIT -> state REQ, inst_addr=0x0040_0000, late data_ok ignored.
REQ-040 With FETCH_ALIGN_CHECK_EN defined, br_target=0x0040_0102 -> no inst_req; fs_valid=1, fs_adel=1, fs_pc=0x0040_0102 until the next redirect.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between the fetch controller, the redirect sources,
// instruction memory and the decode stage.
interface fetch_ctrl_if;
    logic        br_valid;
    logic [31:0] br_target;
    logic        ex_valid;
    logic [31:0] ex_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        ds_allowin;

    modport master (
        input  br_valid, br_target, ex_valid, ex_target,
        input  inst_addr_ok, inst_data_ok, inst_rdata, ds_allowin,
        output inst_req, inst_addr, fs_valid, fs_pc, fs_inst
    );

    modport slave (
        output br_valid, br_target, ex_valid, ex_target,
        output inst_addr_ok, inst_data_ok, inst_rdata, ds_allowin,
        input  inst_req, inst_addr, fs_valid, fs_pc, fs_inst
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding request, branch/exception redirect.
// Defining FETCH_ALIGN_CHECK_EN adds the fs_adel misaligned-fetch flag port.
module fetch_ctrl (
    input  logic         clk,
    input  logic         rst_n,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic         fs_adel,
`endif
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] fs_pc_q;
    logic [31:0] fs_inst_q;
    logic        fs_valid_q;
    logic        adel_q;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        misaligned;

    assign redirect        = bus.ex_valid | bus.br_valid;
    assign redirect_target = bus.ex_valid ? bus.ex_target : bus.br_target;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
    assign fs_adel    = adel_q;
`else
    assign misaligned = 1'b0;
`endif

    assign bus.inst_req  = (state == S_REQ) && !misaligned;
    assign bus.inst_addr = pc;
    assign bus.fs_valid  = fs_valid_q;
    assign bus.fs_pc     = fs_pc_q;
    assign bus.fs_inst   = fs_inst_q;

    // A redirect always loads the PC; the state only records whether a response is still owed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_REQ;
            pc         <= 32'h0040_0000;
            fs_valid_q <= 1'b0;
            fs_pc_q    <= 32'h0;
            fs_inst_q  <= 32'h0;
            adel_q     <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect) begin
                        pc <= redirect_target;
                        if (bus.inst_addr_ok && !misaligned)
                            state <= S_DROP;
                    end else if (misaligned) begin
                        state      <= S_HOLD;
                        fs_valid_q <= 1'b1;
                        adel_q     <= 1'b1;
                        fs_inst_q  <= 32'h0;
                        fs_pc_q    <= pc;
                    end else if (bus.inst_addr_ok) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.inst_data_ok) begin
                        if (redirect) begin
                            pc    <= redirect_target;
                            state <= S_REQ;
                        end else begin
                            fs_inst_q  <= bus.inst_rdata;
                            fs_pc_q    <= pc;
                            fs_valid_q <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end else if (redirect) begin
                        pc    <= redirect_target;
                        state <= S_DROP;
                    end
                end
                S_HOLD: begin
                    // A misaligned-fetch hold can only be left through a redirect.
                    if (redirect) begin
                        pc         <= redirect_target;
                        fs_valid_q <= 1'b0;
                        adel_q     <= 1'b0;
                        state      <= S_REQ;
                    end else if (bus.ds_allowin && !adel_q) begin
                        pc         <= pc + 32'd4;
                        fs_valid_q <= 1'b0;
                        state      <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (redirect)
                        pc <= redirect_target;
                    if (bus.inst_data_ok)
                        state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized
// run against a transaction-level model of the fetch pipeline.
module tb_fetch_ctrl;
    logic clk;
    logic rst_n;
`ifdef FETCH_ALIGN_CHECK_EN
    logic fs_adel;
`endif

    int tests_run;
    int tests_failed;

    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef FETCH_ALIGN_CHECK_EN
        .fs_adel (fs_adel),
`endif
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: PC, whether a response is owed, whether it will be thrown away,
    // and the instruction currently presented to decode.
    logic [31:0] m_pc;
    logic [31:0] m_fpc;
    logic [31:0] m_inst;
    logic        m_owed;
    logic        m_discard;
    logic        m_have;
    logic        m_adel;

    task automatic tick();
        @(posedge clk);
        #1;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.ds_allowin   = 1'b0;
        bus.br_valid     = 1'b0;
        bus.ex_valid     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (bus.inst_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_req: got %b expected 1", bus.inst_req); end
        tests_run++;
        if (bus.inst_addr !== 32'h0040_0000) begin tests_failed++; $display("[TB] FAIL reset_addr: got %h expected 00400000", bus.inst_addr); end
        tests_run++;
        if (bus.fs_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.fs_valid); end
        tests_run++;
        if (bus.fs_pc !== 32'h0 || bus.fs_inst !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_fs: got pc %h inst %h expected 0/0", bus.fs_pc, bus.fs_inst); end
`ifdef FETCH_ALIGN_CHECK_EN
        tests_run++;
        if (fs_adel !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_adel: got %b expected 0", fs_adel); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        tests_run++;
        if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h0040_0000) begin tests_failed++; $display("[TB] FAIL basic_first_req: got req %b addr %h expected 1/00400000", bus.inst_req, bus.inst_addr); end
        bus.inst_addr_ok = 1'b1;
        tick();
        tests_run++;
        if (bus.inst_req !== 1'b0 || bus.fs_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_wait: got req %b valid %b expected 0/0", bus.inst_req, bus.fs_valid); end
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h2402_0001;
        tick();
        tests_run++;
        if (bus.fs_valid !== 1'b1 || bus.fs_inst !== 32'h2402_0001 || bus.fs_pc !== 32'h0040_0000) begin tests_failed++; $display("[TB] FAIL basic_hold: got valid %b inst %h pc %h expected 1/24020001/00400000", bus.fs_valid, bus.fs_inst, bus.fs_pc); end
        bus.ds_allowin = 1'b1;
        tick();
        tests_run++;
        if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h0040_0004 || bus.fs_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_next_req: got req %b addr %h valid %b expected 1/00400004/0", bus.inst_req, bus.inst_addr, bus.fs_valid); end
    endtask

    task automatic test_stall();
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h1111_2222;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.inst_rdata = 32'hDEAD_BEEF;
            tick();
            tests_run++;
            if (bus.fs_valid !== 1'b1 || bus.fs_pc !== 32'h0040_0004 || bus.fs_inst !== 32'h1111_2222 || bus.inst_req !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL stall_%0d: got valid %b pc %h inst %h req %b expected 1/00400004/11112222/0", i, bus.fs_valid, bus.fs_pc, bus.fs_inst, bus.inst_req);
            end
        end
        bus.ds_allowin = 1'b1;
        tick();
        tests_run++;
        if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h0040_0008 || bus.fs_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_release: got req %b addr %h valid %b expected 1/00400008/0", bus.inst_req, bus.inst_addr, bus.fs_valid); end
    endtask

    task automatic test_branch_wait();
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h0040_0100;
        tick();
        tests_run++;
        if (bus.inst_req !== 1'b0 || bus.fs_valid !== 1'b0 || bus.inst_addr !== 32'h0040_0100) begin tests_failed++; $display("[TB] FAIL branch_drop: got req %b valid %b addr %h expected 0/0/00400100", bus.inst_req, bus.fs_valid, bus.inst_addr); end
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h0BAD_0BAD;
        tick();
        tests_run++;
        if (bus.fs_valid !== 1'b0 || bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h0040_0100) begin tests_failed++; $display("[TB] FAIL branch_refetch: got valid %b req %b addr %h expected 0/1/00400100", bus.fs_valid, bus.inst_req, bus.inst_addr); end
    endtask

    task automatic test_ex_priority();
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h3C08_0001;
        tick();
        tests_run++;
        if (bus.fs_valid !== 1'b1 || bus.fs_pc !== 32'h0040_0100) begin tests_failed++; $display("[TB] FAIL ex_hold: got valid %b pc %h expected 1/00400100", bus.fs_valid, bus.fs_pc); end
        bus.ex_valid   = 1'b1;
        bus.ex_target  = 32'hBFC0_0380;
        bus.br_valid   = 1'b1;
        bus.br_target  = 32'h0040_0100;
        bus.ds_allowin = 1'b1;
        tick();
        tests_run++;
        if (bus.fs_valid !== 1'b0 || bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0380) begin tests_failed++; $display("[TB] FAIL ex_priority: got valid %b req %b addr %h expected 0/1/bfc00380", bus.fs_valid, bus.inst_req, bus.inst_addr); end
    endtask

    task automatic test_wrap();
        bus.br_valid  = 1'b1;
        bus.br_target = 32'hFFFF_FFFC;
        tick();
        tests_run++;
        if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("[TB] FAIL wrap_redirect_req: got req %b addr %h expected 1/fffffffc", bus.inst_req, bus.inst_addr); end
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h0000_000C;
        tick();
        tests_run++;
        if (bus.fs_valid !== 1'b1 || bus.fs_pc !== 32'hFFFF_FFFC) begin tests_failed++; $display("[TB] FAIL wrap_hold: got valid %b pc %h expected 1/fffffffc", bus.fs_valid, bus.fs_pc); end
        bus.ds_allowin = 1'b1;
        tick();
        tests_run++;
        if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h0000_0000) begin tests_failed++; $display("[TB] FAIL wrap_next: got req %b addr %h expected 1/00000000", bus.inst_req, bus.inst_addr); end
    endtask

    task automatic test_reset_mid();
        bus.inst_addr_ok = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h0040_0000 || bus.fs_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_async: got req %b addr %h valid %b expected 1/00400000/0", bus.inst_req, bus.inst_addr, bus.fs_valid); end
        tick();
        rst_n = 1'b1;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'hFEED_FACE;
        tick();
        tests_run++;
        if (bus.fs_valid !== 1'b0 || bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h0040_0000) begin tests_failed++; $display("[TB] FAIL midreset_late_data: got valid %b req %b addr %h expected 0/1/00400000", bus.fs_valid, bus.inst_req, bus.inst_addr); end
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h1234_5678;
        tick();
        tests_run++;
        if (bus.fs_valid !== 1'b1 || bus.fs_pc !== 32'h0040_0000 || bus.fs_inst !== 32'h1234_5678) begin tests_failed++; $display("[TB] FAIL midreset_refetch: got valid %b pc %h inst %h expected 1/00400000/12345678", bus.fs_valid, bus.fs_pc, bus.fs_inst); end
        bus.ds_allowin = 1'b1;
        tick();
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    task automatic test_align();
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h0040_0102;
        tick();
        tests_run++;
        if (bus.inst_req !== 1'b0 || bus.inst_addr !== 32'h0040_0102) begin tests_failed++; $display("[TB] FAIL align_noreq: got req %b addr %h expected 0/00400102", bus.inst_req, bus.inst_addr); end
        bus.inst_addr_ok = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (bus.fs_valid !== 1'b1 || fs_adel !== 1'b1 || bus.fs_pc !== 32'h0040_0102 || bus.fs_inst !== 32'h0 || bus.inst_req !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL align_hold_%0d: got valid %b adel %b pc %h inst %h req %b expected 1/1/00400102/0/0", i, bus.fs_valid, fs_adel, bus.fs_pc, bus.fs_inst, bus.inst_req);
            end
            bus.ds_allowin = 1'b1;
            tick();
        end
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h0040_0200;
        tick();
        tests_run++;
        if (bus.fs_valid !== 1'b0 || fs_adel !== 1'b0 || bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h0040_0200) begin tests_failed++; $display("[TB] FAIL align_exit: got valid %b adel %b req %b addr %h expected 0/0/1/00400200", bus.fs_valid, fs_adel, bus.inst_req, bus.inst_addr); end
    endtask
`endif

    task automatic test_random();
        logic        aok, dok, alw, bv, ev, r, mis;
        logic [31:0] rd, bt, et, tgt;
        logic        exp_req;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_pc = 32'h0040_0000; m_fpc = 32'h0; m_inst = 32'h0;
        m_owed = 1'b0; m_discard = 1'b0; m_have = 1'b0; m_adel = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
`ifdef FETCH_ALIGN_CHECK_EN
            mis = (m_pc[1:0] != 2'b00);
`else
            mis = 1'b0;
`endif
            exp_req = !m_owed && !m_have && !mis;
            tests_run++;
            if (bus.inst_req !== exp_req) begin tests_failed++; $display("[TB] FAIL rand_req cyc %0d: got %b expected %b", cyc, bus.inst_req, exp_req); end
            tests_run++;
            if (bus.inst_addr !== m_pc) begin tests_failed++; $display("[TB] FAIL rand_addr cyc %0d: got %h expected %h", cyc, bus.inst_addr, m_pc); end
            tests_run++;
            if (bus.fs_valid !== m_have) begin tests_failed++; $display("[TB] FAIL rand_valid cyc %0d: got %b expected %b", cyc, bus.fs_valid, m_have); end
            if (m_have) begin
                tests_run++;
                if (bus.fs_pc !== m_fpc || bus.fs_inst !== m_inst) begin tests_failed++; $display("[TB] FAIL rand_fs cyc %0d: got pc %h inst %h expected %h/%h", cyc, bus.fs_pc, bus.fs_inst, m_fpc, m_inst); end
`ifdef FETCH_ALIGN_CHECK_EN
                tests_run++;
                if (fs_adel !== m_adel) begin tests_failed++; $display("[TB] FAIL rand_adel cyc %0d: got %b expected %b", cyc, fs_adel, m_adel); end
`endif
            end

            aok = ($urandom_range(0, 1) == 1);
            dok = ($urandom_range(0, 2) != 0);
            alw = ($urandom_range(0, 1) == 1);
            bv  = ($urandom_range(0, 7) == 0);
            ev  = ($urandom_range(0, 11) == 0);
            rd  = $urandom;
            bt  = $urandom;
            et  = $urandom;
            if ($urandom_range(0, 3) != 0) bt = bt & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) != 0) et = et & 32'hFFFF_FFFC;
            bus.inst_addr_ok = aok; bus.inst_data_ok = dok; bus.inst_rdata = rd;
            bus.ds_allowin = alw; bus.br_valid = bv; bus.br_target = bt;
            bus.ex_valid = ev; bus.ex_target = et;

            @(posedge clk);
            r   = ev | bv;
            tgt = ev ? et : bt;
            if (m_have) begin
                if (r) begin
                    m_have = 1'b0; m_adel = 1'b0; m_pc = tgt;
                end else if (alw && !m_adel) begin
                    m_have = 1'b0; m_pc = m_pc + 32'd4;
                end
            end else if (m_owed) begin
                if (dok) begin
                    if (!m_discard && !r) begin m_have = 1'b1; m_inst = rd; m_fpc = m_pc; end
                    m_owed = 1'b0; m_discard = 1'b0;
                end else if (r) begin
                    m_discard = 1'b1;
                end
                if (r) m_pc = tgt;
            end else begin
                if (r) begin
                    if (aok && !mis) begin m_owed = 1'b1; m_discard = 1'b1; end
                    m_pc = tgt;
                end else if (mis) begin
                    m_have = 1'b1; m_adel = 1'b1; m_inst = 32'h0; m_fpc = m_pc;
                end else if (aok) begin
                    m_owed = 1'b1; m_discard = 1'b0;
                end
            end
            #1;
        end
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        rst_n            = 1'b0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        bus.ds_allowin   = 1'b0;
        bus.br_valid     = 1'b0;
        bus.br_target    = 32'h0;
        bus.ex_valid     = 1'b0;
        bus.ex_target    = 32'h0;

        test_reset();
        test_basic();
        test_stall();
        test_branch_wait();
        test_ex_priority();
        test_wrap();
        test_reset_mid();
`ifdef FETCH_ALIGN_CHECK_EN
        test_align();
`endif
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
